// File: rtl/adc_poll_seq.sv
// Round-robin ADC poller: drives a 16-bit SPI master and returns one result per channel frame.
// It generates sclk, issues a per-channel command word and strobes each result for one cycle.
module adc_poll_seq #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned RES_BITS = 10,
    parameter int unsigned GAP_CYC  = 16,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                sclk,
    output logic                spi_xmit,
    output logic [15:0]         tx_data,
    input  logic [15:0]         rx_data,
    input  logic                ss,
    output logic [RES_BITS-1:0] sample,
    output logic [1:0]          sample_ch,
    output logic                sample_valid,
    output logic                err,
    output logic                busy
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoad     = 3'd1;
    localparam logic [2:0] StStart    = 3'd2;
    localparam logic [2:0] StWaitLow  = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;
    localparam logic [2:0] StStore    = 3'd5;
    localparam logic [2:0] StGap      = 3'd6;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic [2:0]          state_q, state_d;
    logic [1:0]          ch_q, ch_d;
    logic [7:0]          div_q;
    logic                sclk_q;
    logic [TW-1:0]       to_q;
    logic [GW-1:0]       gap_q;
    logic [15:0]         tx_q;
    logic [RES_BITS-1:0] sample_q;
    logic [1:0]          sample_ch_q;
    logic                err_q;
    logic                timeout;
    logic                to_last;
    logic                gap_last;
    logic [2:0]          after_gap;
    logic [2:0]          after_frame;
    logic                unused_rx;

    assign unused_rx = ^rx_data;

    assign to_last   = (to_q == TW'(TIMEOUT - 1));
    assign gap_last  = (gap_q == GW'(GAP_CYC - 1));
    assign after_gap = en ? StLoad : StIdle;
    // With no gap configured the GAP state is skipped entirely.
    assign after_frame = (GAP_CYC == 0) ? after_gap : StGap;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        timeout = 1'b0;
        unique case (state_q)
            StIdle:     if (en) state_d = StLoad;
            StLoad:     state_d = StStart;
            StStart:    state_d = StWaitLow;
            StWaitLow: begin
                if (!ss) state_d = StWaitHigh;
                else if (to_last) timeout = 1'b1;
            end
            StWaitHigh: begin
                if (ss) state_d = StStore;
                else if (to_last) timeout = 1'b1;
            end
            StStore: begin
                ch_d    = (ch_q == 2'(NUM_CH - 1)) ? 2'd0 : ch_q + 2'd1;
                state_d = after_frame;
            end
            StGap:      if (gap_last) state_d = after_gap;
            default:    state_d = StIdle;
        endcase
        // Abort keeps the channel so the same one is retried.
        if (timeout) state_d = after_frame;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ch_q        <= 2'd0;
            div_q       <= 8'd0;
            sclk_q      <= 1'b0;
            to_q        <= '0;
            gap_q       <= '0;
            tx_q        <= 16'h0000;
            sample_q    <= '0;
            sample_ch_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;

            if (state_d == StIdle) begin
                div_q  <= 8'd0;
                sclk_q <= 1'b0;
            end else if (div_q == 8'(CLK_DIV - 1)) begin
                div_q  <= 8'd0;
                sclk_q <= ~sclk_q;
            end else begin
                div_q <= div_q + 8'd1;
            end

            if (state_q == StStart) begin
                to_q <= '0;
            end else if (state_q == StWaitLow || state_q == StWaitHigh) begin
                to_q <= to_q + TW'(1);
            end

            gap_q <= (state_q == StGap) ? gap_q + GW'(1) : '0;

            if (state_d == StLoad && state_q != StLoad) begin
                tx_q <= {3'b011, ch_d, 11'b0};
            end

            // Capture on entry to STORE so the result is valid alongside the strobe.
            if (state_d == StStore && state_q != StStore) begin
                sample_q    <= rx_data[RES_BITS-1:0];
                sample_ch_q <= ch_q;
            end

            if (timeout) err_q <= 1'b1;
        end
    end

    assign sclk         = sclk_q;
    assign spi_xmit     = !(state_q == StStart || state_q == StWaitLow);
    assign tx_data      = tx_q;
    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = (state_q == StStore);
    assign err          = err_q;
    assign busy         = (state_q == StStart) || (state_q == StWaitLow) ||
                          (state_q == StWaitHigh) || (state_q == StStore);

endmodule

// File: tb/tb_adc_poll_seq.sv
// Bench for adc_poll_seq: two instances (GAP_CYC=3 and GAP_CYC=0) driven by a scripted SPI master,
// with expected channels and results computed from the channel rotation and frame responses.
module tb_adc_poll_seq;

    localparam int unsigned CDIV = 2;
    localparam int unsigned NCH  = 2;
    localparam int unsigned RB   = 10;
    localparam int unsigned TO   = 64;
    localparam logic [32:0] RST_OUTS = {1'b0, 1'b1, 31'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        en [2];
    logic        ss [2];
    logic [15:0] rx_data [2];
    logic        sclk [2];
    logic        spi_xmit [2];
    logic [15:0] tx_data [2];
    logic [9:0]  sample [2];
    logic [1:0]  sample_ch [2];
    logic        sample_valid [2];
    logic        err [2];
    logic        busy [2];

    int total = 0;
    int bad   = 0;
    int exp_ch [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        adc_poll_seq #(
            .CLK_DIV (CDIV),
            .NUM_CH  (NCH),
            .RES_BITS(RB),
            .GAP_CYC ((g == 0) ? 3 : 0),
            .TIMEOUT (TO)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en[g]),
            .sclk        (sclk[g]),
            .spi_xmit    (spi_xmit[g]),
            .tx_data     (tx_data[g]),
            .rx_data     (rx_data[g]),
            .ss          (ss[g]),
            .sample      (sample[g]),
            .sample_ch   (sample_ch[g]),
            .sample_valid(sample_valid[g]),
            .err         (err[g]),
            .busy        (busy[g])
        );
    end

    function automatic int gap_of(input int g);
        return (g == 0) ? 3 : 0;
    endfunction

    function automatic logic [32:0] outs(input int g);
        return {sclk[g], spi_xmit[g], tx_data[g], sample[g], sample_ch[g],
                sample_valid[g], err[g], busy[g]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            en[g] = 1'b0; ss[g] = 1'b1; rx_data[g] = 16'h0000; exp_ch[g] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One SPI frame from the master's side; returns at the STORE cycle.
    task automatic run_frame(input int g, input logic [15:0] resp, input bit drop_en,
                             input string tag);
        int n, lat, len, last_t, toggles;
        bit per_ok;
        logic s_prev;
        logic [15:0] want_tx;
        n = 0;
        while (spi_xmit[g] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL %s start: spi_xmit never fell", tag); end
        want_tx = {3'b011, 2'(exp_ch[g]), 11'b0};
        total++;
        if (tx_data[g] !== want_tx) begin
            bad++; $display("FAIL %s tx_data: got %h want %h", tag, tx_data[g], want_tx);
        end
        lat = $urandom_range(0, 3);
        repeat (lat) @(negedge clk);
        ss[g] = 1'b0;
        len = $urandom_range(10, 24);
        toggles = 0; last_t = -1; per_ok = 1'b1; s_prev = sclk[g];
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            rx_data[g] = 16'($urandom);
            if (sclk[g] !== s_prev) begin
                if (last_t >= 0 && (i - last_t) != int'(CDIV)) per_ok = 1'b0;
                last_t = i; toggles++;
            end
            s_prev = sclk[g];
        end
        total++;
        if (!per_ok || toggles < 2) begin
            bad++; $display("FAIL %s sclk: toggles=%0d period_ok=%0d want period %0d",
                            tag, toggles, per_ok, CDIV);
        end
        total++;
        if (busy[g] !== 1'b1 || spi_xmit[g] !== 1'b1) begin
            bad++; $display("FAIL %s wait_high: busy=%b xmit=%b want 1 1", tag, busy[g], spi_xmit[g]);
        end
        if (drop_en) en[g] = 1'b0;
        rx_data[g] = resp;
        ss[g] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (sample_valid[g] !== 1'b1 && n < 10);
        total++;
        if (n != 1) begin bad++; $display("FAIL %s valid latency: got %0d want 1", tag, n); end
        total++;
        if ({sample[g], sample_ch[g]} !== {resp[RB-1:0], 2'(exp_ch[g])}) begin
            bad++; $display("FAIL %s sample: got %h/ch%0d want %h/ch%0d", tag, sample[g],
                            sample_ch[g], resp[RB-1:0], exp_ch[g]);
        end
        exp_ch[g] = (exp_ch[g] + 1) % NCH;
    endtask

    // From STORE, count cycles up to the next START.
    task automatic check_gap(input int g, input string tag);
        int n;
        @(negedge clk);
        n = 1;
        total++;
        if (sample_valid[g] !== 1'b0) begin
            bad++; $display("FAIL %s strobe width: valid=%b want 0", tag, sample_valid[g]);
        end
        while (spi_xmit[g] !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n != gap_of(g) + 2) begin
            bad++; $display("FAIL %s gap: got %0d want %0d", tag, n, gap_of(g) + 2);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int g = 0; g < 2; g++) begin
            total++;
            if (outs(g) !== RST_OUTS) begin
                bad++; $display("FAIL reset dut%0d: got %h want %h", g, outs(g), RST_OUTS);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        en[0] = 1'b1;
        n = 0;
        while (spi_xmit[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        ss[0] = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy[0] !== 1'b1 || spi_xmit[0] !== 1'b1) begin
            bad++; $display("FAIL reset_mid pre: busy=%b xmit=%b want 1 1", busy[0], spi_xmit[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs(0) !== RST_OUTS) begin
            bad++; $display("FAIL reset_mid async: got %h want %h", outs(0), RST_OUTS);
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        do_reset();
        en[0] = 1'b1;
        run_frame(0, 16'h03A5, 1'b0, "single");
        check_gap(0, "single");
    endtask

    task automatic test_round_robin();
        do_reset();
        en[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_frame(0, 16'($urandom), 1'b0, "rr");
            check_gap(0, "rr");
        end
    endtask

    task automatic test_en_drop();
        logic [15:0] resp;
        int odd;
        do_reset();
        en[0] = 1'b1;
        resp = 16'($urandom);
        run_frame(0, resp, 1'b1, "en_drop");
        repeat (6) @(negedge clk);
        odd = 0;
        for (int i = 0; i < 30; i++) begin
            if (sclk[0] !== 1'b0 || spi_xmit[0] !== 1'b1 || busy[0] !== 1'b0 ||
                sample_valid[0] !== 1'b0) odd++;
            @(negedge clk);
        end
        total++;
        if (odd != 0) begin bad++; $display("FAIL en_drop idle: got %0d active cycles want 0", odd); end
        total++;
        if (sample[0] !== resp[RB-1:0]) begin
            bad++; $display("FAIL en_drop hold: got %h want %h", sample[0], resp[RB-1:0]);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        do_reset();
        en[0] = 1'b1;
        n = 0;
        while (spi_xmit[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 0; seen = 1'b0;
        while (err[0] !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
            if (sample_valid[0] === 1'b1) seen = 1'b1;
        end
        total++;
        if (n != int'(TO) + 1) begin bad++; $display("FAIL timeout cycles: got %0d want %0d", n, TO + 1); end
        total++;
        if (seen) begin bad++; $display("FAIL timeout strobe: got valid want none"); end
        total++;
        if (spi_xmit[0] !== 1'b1) begin bad++; $display("FAIL timeout xmit: got %b want 1", spi_xmit[0]); end
        run_frame(0, 16'($urandom), 1'b0, "retry");
        total++;
        if (err[0] !== 1'b1) begin bad++; $display("FAIL err sticky: got %b want 1", err[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_frame(1, 16'($urandom), 1'b0, "gap0");
            check_gap(1, "gap0");
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            en[g] = 1'b0; ss[g] = 1'b1; rx_data[g] = 16'h0000; exp_ch[g] = 0;
        end
        test_reset();
        test_reset_mid();
        test_single_frame();
        test_round_robin();
        test_en_drop();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_poll_seq.md
Name: adc_poll_seq

Overview:
- Transaction sequencer that sits directly upstream of the 16-bit SPI master and also consumes its results.
- Generates the SPI bit clock and builds a per-channel ADC command word.
- Drives the master's transmit control, waits for the slave-select frame to complete, and extracts the conversion result from the received word.
- Round-robins channels continuously and presents each result with a one-cycle valid strobe to the LED/PWM logic downstream.

Parameters:
- CLK_DIV, 8, clk cycles per sclk half-period (sclk period = 2*CLK_DIV); legal range 2..255.
- NUM_CH, 2, number of channels polled (1..4); channel index 0..NUM_CH-1.
- RES_BITS, 10, conversion result width taken from rx_data LSBs (1..16).
- GAP_CYC, 16, idle clk cycles between frames (0..65535).
- TIMEOUT, 4096, clk cycles allowed per frame before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = poll continuously; 0 = finish the current frame, then idle.
- sclk  out  1  SPI bit clock to the master.
- spi_xmit  out  1  master transmit control: 1 = hold idle and load tx_data; 0 = start a frame.
- tx_data  out  16  command word to the master.
- rx_data  in  16  received word from the master.
- ss  in  1  slave select from the master: low during a frame, returns high at frame end.
- sample  out  RES_BITS  last conversion result.
- sample_ch  out  2  channel of sample.
- sample_valid  out  1  one-cycle strobe; sample and sample_ch are valid in the same cycle.
- err  out  1  sticky timeout flag; cleared by reset only.
- busy  out  1  high from the START state through STORE.

Behaviour:
- Reset: async assert on rst_n=0. All outputs and state clear at once: sclk=0, spi_xmit=1, tx_data=0, sample=0, sample_ch=0, sample_valid=0, err=0, busy=0, state=IDLE, channel=0, counters=0.
- sclk:
  - Divider counts 0..CLK_DIV-1; sclk toggles on wrap.
  - Runs only while state is not IDLE. In IDLE, sclk is forced 0 and the divider is cleared.
- Command word: tx_data = {1'b0, 1'b1 (start), 1'b1 (single-ended), ch[1:0], 11'b0}. Registered on entry to LOAD; held stable until the next LOAD.
- States:
  - IDLE: spi_xmit=1. If en=1, go to LOAD.
  - LOAD: spi_xmit=1 for exactly 1 cycle so the master latches tx_data. Then go to START.
  - START: spi_xmit=0; clear the timeout counter. Go to WAIT_LOW.
  - WAIT_LOW: keep spi_xmit=0 until ss=0 is seen, then set spi_xmit=1 and go to WAIT_HIGH. spi_xmit=1 prevents a retrigger when ss rises.
  - WAIT_HIGH: wait for ss=1, then go to STORE.
  - STORE: sample <= rx_data[RES_BITS-1:0]; sample_ch <= ch; sample_valid=1 for this 1 cycle. Advance ch; wrap from NUM_CH-1 to 0. Go to GAP.
  - GAP: count GAP_CYC cycles; GAP_CYC=0 means 0 cycles in GAP. Then go to LOAD if en=1, else IDLE.
- Timeout:
  - Counter runs in WAIT_LOW and WAIT_HIGH.
  - Reaching TIMEOUT sets err=1, spi_xmit=1, and goes to GAP.
  - On timeout there is no sample_valid and ch does not advance (same channel is retried).
- en deassert mid-frame: the frame completes normally, including STORE. The next transition from GAP goes to IDLE.
- ss already low in START (master out of sync): treated as ss low; normal path taken.
- sample and sample_ch hold their value between strobes.
- Latency, en rise to sample_valid: 3 cycles (IDLE, LOAD, START) plus frame time plus 1 cycle (STORE).

Test Plan:
- Reset mid-frame: rst_n low while in WAIT_HIGH -> in the same cycle spi_xmit=1, sclk=0, busy=0, err=0; all outputs 0 except spi_xmit.
- Single frame, CLK_DIV=2, NUM_CH=2, SPI master model returns 16'h03A5 -> tx_data=16'h6000, then sample=10'h3A5, sample_ch=0, sample_valid high for exactly 1 cycle.
- Round-robin over 5 frames -> sample_ch sequence 0,1,0,1,0; tx_data sequence 6000,6800,6000,6800,6000.
- en dropped while in WAIT_HIGH -> that frame still strobes sample_valid; FSM then reaches IDLE and sclk stays 0 while idle.
- ss held high forever, TIMEOUT=64 -> err=1 after 64 cycles in WAIT_LOW, no sample_valid; next frame uses the same channel.
- GAP_CYC=0 -> STORE is followed directly by LOAD; exactly one LOAD cycle with spi_xmit=1 between frames.
